// File: rtl/router_output_port_ctrl.sv
// router_output_port_ctrl
// Per-output-port controller for one NoC router output direction.
// Round-robin arbitration among N_IN input ports with wormhole packet lock,
// credit-gated forwarding, and a sticky credit-overflow flag.
// Optional statistics counters are enabled with ROUTER_OUTPUT_PORT_CTRL_STATS_EN.
module router_output_port_ctrl #(
  parameter int N_IN    = 5,
  parameter int CREDITS = 4,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  request,
  input  logic [N_IN-1:0]  req_head,
  input  logic [N_IN-1:0]  req_tail,
  input  logic             credit_in,
  output logic [N_IN-1:0]  grant,
  output logic             fwd_valid,
  output logic             busy,
  output logic [CNT_W-1:0] credits_avail,
  output logic             credit_err
`ifdef ROUTER_OUTPUT_PORT_CTRL_STATS_EN
  ,
  output logic [31:0]      pkt_count,
  output logic [31:0]      stall_count
`endif
);

  localparam int PTR_W = $clog2(N_IN);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] credits_q;
  logic             credit_err_q;

  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W:0]   idx;
  logic             credit_ok;
  logic             pending;
  logic             tail_fwd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_IN - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration, packet lock and grant generation; grant is forced low during reset
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    grant     = '0;
    found     = 1'b0;
    win       = '0;
    idx       = '0;
    pending   = 1'b0;
    tail_fwd  = 1'b0;
    credit_ok = (credits_q != '0);
    case (state_q)
      IDLE: begin
        for (int unsigned k = 0; k < N_IN; k++) begin
          idx = {1'b0, rr_q} + (PTR_W + 1)'(k);
          if (idx >= (PTR_W + 1)'(N_IN)) idx = idx - (PTR_W + 1)'(N_IN);
          if (!found && request[idx[PTR_W-1:0]] && req_head[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            win   = idx[PTR_W-1:0];
          end
        end
        pending = found;
        if (found && credit_ok) begin
          grant[win] = 1'b1;
          if (req_tail[win]) begin
            tail_fwd = 1'b1;
            rr_d     = ptr_inc(win);
          end else begin
            state_d = LOCKED;
            owner_d = win;
          end
        end
      end
      LOCKED: begin
        pending = request[owner_q];
        if (pending && credit_ok) begin
          grant[owner_q] = 1'b1;
          if (req_tail[owner_q]) begin
            tail_fwd = 1'b1;
            state_d  = IDLE;
            rr_d     = ptr_inc(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) grant = '0;
  end

  assign fwd_valid     = |grant;
  assign busy          = (state_q == LOCKED);
  assign credits_avail = credits_q;
  assign credit_err    = credit_err_q;

  // State, round-robin pointer and owner registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Downstream credit counter with saturation and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q    <= CNT_W'(CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      case ({fwd_valid, credit_in})
        2'b10: credits_q <= credits_q - 1'b1;
        2'b01: begin
          if (credits_q == CNT_W'(CREDITS)) credit_err_q <= 1'b1;
          else                              credits_q    <= credits_q + 1'b1;
        end
        default: credits_q <= credits_q;
      endcase
    end
  end

`ifdef ROUTER_OUTPUT_PORT_CTRL_STATS_EN
  // Packet and credit-stall statistics, free-running with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (tail_fwd)               pkt_count   <= pkt_count + 1'b1;
      if (pending && !credit_ok)  stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_output_port_ctrl.sv
// Directed self-checking bench for router_output_port_ctrl (default build).
module tb_router_output_port_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] request, req_head, req_tail;
  logic       credit_in;
  logic [4:0] grant;
  logic       fwd_valid, busy, credit_err;
  logic [2:0] credits_avail;

  int n_tests = 0;
  int n_fail  = 0;

  router_output_port_ctrl #(.N_IN(5), .CREDITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .request      (request),
    .req_head     (req_head),
    .req_tail     (req_tail),
    .credit_in    (credit_in),
    .grant        (grant),
    .fwd_valid    (fwd_valid),
    .busy         (busy),
    .credits_avail(credits_avail),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t,
                       input logic c);
    request   = r;
    req_head  = h;
    req_tail  = t;
    credit_in = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_fwd", 32'(fwd_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_credits", 32'(credits_avail), 32'd4);
    chk("rst_err", 32'(credit_err), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // request without head in IDLE is ignored
    drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
    chk("nohead_grant", 32'(grant), 32'h0);
    tick();

    // two single-flit packets from inputs 1 and 2
    drive(5'b00110, 5'b00110, 5'b00110, 1'b0);
    chk("rr_first", 32'(grant), 32'h02);
    chk("rr_fwd", 32'(fwd_valid), 32'h1);
    tick();
    chk("rr_second", 32'(grant), 32'h04);
    tick();
    chk("rr_credits2", 32'(credits_avail), 32'd2);
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    tick();
    tick();
    chk("refill4", 32'(credits_avail), 32'd4);
    // rr_ptr now 3: input 3 must beat 0..2
    drive(5'b01111, 5'b01111, 5'b01111, 1'b0);
    chk("rr_ptr3", 32'(grant), 32'h08);
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    tick();
    chk("refill4b", 32'(credits_avail), 32'd4);

    // wormhole: input 0 head,body,tail while input 1 requests (rr_ptr=4)
    drive(5'b00011, 5'b00011, 5'b00010, 1'b0);
    chk("wh_head", 32'(grant), 32'h01);
    tick();
    chk("wh_busy1", 32'(busy), 32'h1);
    drive(5'b00011, 5'b00010, 5'b00010, 1'b0);
    chk("wh_body", 32'(grant), 32'h01);
    tick();
    chk("wh_busy2", 32'(busy), 32'h1);
    drive(5'b00011, 5'b00011, 5'b00011, 1'b0);
    chk("wh_tail", 32'(grant), 32'h01);
    tick();
    chk("wh_idle", 32'(busy), 32'h0);
    drive(5'b00010, 5'b00010, 5'b00010, 1'b0);
    chk("wh_next", 32'(grant), 32'h02);
    tick();
    chk("wh_credits0", 32'(credits_avail), 32'd0);
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    repeat (4) tick();
    chk("refill4c", 32'(credits_avail), 32'd4);

    // 6-flit packet on input 2 (rr_ptr=2) with 4 credits
    drive(5'b00100, 5'b00100, 5'b00000, 1'b0);
    chk("long_f1", 32'(grant), 32'h04);
    tick();
    drive(5'b00100, 5'b00000, 5'b00000, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      chk("long_fmid", 32'(grant), 32'h04);
      tick();
    end
    chk("long_cred0", 32'(credits_avail), 32'd0);
    chk("long_stall", 32'(grant), 32'h0);
    chk("long_stall_fwd", 32'(fwd_valid), 32'h0);
    drive(5'b00100, 5'b00000, 5'b00000, 1'b1);
    chk("credit_same_cycle", 32'(grant), 32'h0);
    tick();
    chk("credit_next", 32'(credits_avail), 32'd1);
    drive(5'b00100, 5'b00000, 5'b00000, 1'b0);
    chk("long_f5", 32'(grant), 32'h04);
    tick();
    chk("long_cred0b", 32'(credits_avail), 32'd0);
    chk("long_stall2", 32'(grant), 32'h0);
    drive(5'b00100, 5'b00000, 5'b00000, 1'b1);
    tick();
    // tail forwarded together with a returning credit: count unchanged
    drive(5'b00100, 5'b00000, 5'b00100, 1'b1);
    chk("long_f6", 32'(grant), 32'h04);
    tick();
    chk("simul_cred", 32'(credits_avail), 32'd1);
    chk("long_done", 32'(busy), 32'h0);
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    repeat (3) tick();
    chk("refill_full", 32'(credits_avail), 32'd4);
    chk("err_clear", 32'(credit_err), 32'h0);
    tick();
    chk("sat_credits", 32'(credits_avail), 32'd4);
    chk("err_set", 32'(credit_err), 32'h1);
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    tick();
    chk("err_sticky", 32'(credit_err), 32'h1);

    // reset mid-packet on input 3 (rr_ptr=3)
    drive(5'b01000, 5'b01000, 5'b00000, 1'b0);
    chk("mp_head", 32'(grant), 32'h08);
    tick();
    chk("mp_busy", 32'(busy), 32'h1);
    drive(5'b01000, 5'b00000, 5'b00000, 1'b0);
    chk("mp_body", 32'(grant), 32'h08);
    rst = 1'b1;
    #1;
    chk("mp_rst_grant", 32'(grant), 32'h0);
    chk("mp_rst_busy", 32'(busy), 32'h0);
    chk("mp_rst_credits", 32'(credits_avail), 32'd4);
    chk("mp_rst_err", 32'(credit_err), 32'h0);
    tick();
    rst = 1'b0;
    drive(5'b11111, 5'b11111, 5'b11111, 1'b0);
    chk("mp_rr0", 32'(grant), 32'h01);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
